commit_trace_checker: RTL and testbench

// Self-checking commit monitor for the single-cycle core's simulation and FPGA bring-up.

---
 rtl/commit_trace_checker.sv | 173 +++++++++++++++++
 tb/tb_commit_trace_checker.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/commit_trace_checker.sv
// Commit-trace checker: compares retired instructions against a preloaded expected trace
// and reports pass/fail, first failure, error count, watchdog timeout and x0 writes.
module commit_trace_checker #(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned DEPTH        = 128,
  parameter int unsigned TIMEOUT      = 1024,
  parameter int unsigned HALT_ON_FAIL = 1,
  localparam int unsigned AW          = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned WW          = $clog2(TIMEOUT) + 1
) (
  input  logic            clk_100mhz,
  input  logic            rst_in,
  input  logic            load_valid_in,
  input  logic [AW-1:0]   load_addr_in,
  input  logic [XLEN-1:0] load_pc_in,
  input  logic [4:0]      load_rd_in,
  input  logic            load_we_in,
  input  logic [XLEN-1:0] load_data_in,
  input  logic [AW:0]     num_entries_in,
  input  logic            start_in,
  input  logic            commit_valid_in,
  input  logic [XLEN-1:0] commit_pc_in,
  input  logic [4:0]      commit_rd_in,
  input  logic            commit_we_in,
  input  logic [XLEN-1:0] commit_data_in,
  output logic            busy_out,
  output logic            done_out,
  output logic            pass_out,
  output logic            timeout_out,
  output logic            x0_violation_out,
  output logic [AW:0]     err_count_out,
  output logic [AW-1:0]   fail_index_out,
  output logic [XLEN-1:0] fail_pc_out
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  localparam logic [AW:0]   DEPTH_W = (AW+1)'(DEPTH);
  localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [AW-1:0]     idx_q, idx_d;
  logic [AW:0]       num_q, num_d;
  logic [AW:0]       err_q, err_d;
  logic              timeout_q, timeout_d;
  logic              x0_q, x0_d;
  logic              bad_start_q, bad_start_d;
  logic [AW-1:0]     fidx_q, fidx_d;
  logic [XLEN-1:0]   fpc_q, fpc_d;
  logic [WW-1:0]     wd_q, wd_d;

  logic [XLEN-1:0]   mem_pc   [DEPTH];
  logic [XLEN-1:0]   mem_data [DEPTH];
  logic [4:0]        mem_rd   [DEPTH];
  logic              mem_we   [DEPTH];

  logic [XLEN-1:0]   exp_pc, exp_data;
  logic [4:0]        exp_rd;
  logic              exp_we;
  logic              x0_hit, mismatch, last_entry, start_ok;

  // Trace memory is deliberately outside reset so a run can be restarted without reloading.
  always_ff @(posedge clk_100mhz) begin
    if (load_valid_in && (state_q != S_RUN)) begin
      mem_pc[load_addr_in]   <= load_pc_in;
      mem_rd[load_addr_in]   <= load_rd_in;
      mem_we[load_addr_in]   <= load_we_in;
      mem_data[load_addr_in] <= load_data_in;
    end
  end

  always_comb begin
    exp_pc     = mem_pc[idx_q];
    exp_rd     = mem_rd[idx_q];
    exp_we     = mem_we[idx_q];
    exp_data   = mem_data[idx_q];
    x0_hit     = commit_we_in && (commit_rd_in == 5'd0);
    mismatch   = (commit_pc_in != exp_pc) || (commit_we_in != exp_we) ||
                 (exp_we && ((commit_rd_in != exp_rd) || (commit_data_in != exp_data))) ||
                 x0_hit;
    last_entry = ({1'b0, idx_q} == (num_q - (AW+1)'(1)));
    start_ok   = (num_entries_in != '0) && (num_entries_in <= DEPTH_W);
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    num_d       = num_q;
    err_d       = err_q;
    timeout_d   = timeout_q;
    x0_d        = x0_q;
    bad_start_d = bad_start_q;
    fidx_d      = fidx_q;
    fpc_d       = fpc_q;
    wd_d        = wd_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_in) begin
          idx_d       = '0;
          err_d       = '0;
          timeout_d   = 1'b0;
          x0_d        = 1'b0;
          fidx_d      = '0;
          fpc_d       = '0;
          wd_d        = '0;
          num_d       = num_entries_in;
          bad_start_d = !start_ok;
          state_d     = start_ok ? S_RUN : S_DONE;
        end
      end
      S_RUN: begin
        if (commit_valid_in) begin
          wd_d  = '0;
          idx_d = idx_q + AW'(1);
          if (x0_hit) x0_d = 1'b1;
          if (mismatch) begin
            if (err_q != '1) err_d = err_q + (AW+1)'(1);
            if (err_q == '0) begin
              fidx_d = idx_q;
              fpc_d  = commit_pc_in;
            end
          end
          if (last_entry || ((HALT_ON_FAIL != 0) && mismatch)) state_d = S_DONE;
        end else if (wd_q == WD_LAST) begin
          // A commit in the watchdog's final cycle takes the branch above instead.
          timeout_d = 1'b1;
          state_d   = S_DONE;
        end else begin
          wd_d = wd_q + WW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_100mhz) begin
    if (!rst_in) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      num_q       <= '0;
      err_q       <= '0;
      timeout_q   <= 1'b0;
      x0_q        <= 1'b0;
      bad_start_q <= 1'b0;
      fidx_q      <= '0;
      fpc_q       <= '0;
      wd_q        <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      num_q       <= num_d;
      err_q       <= err_d;
      timeout_q   <= timeout_d;
      x0_q        <= x0_d;
      bad_start_q <= bad_start_d;
      fidx_q      <= fidx_d;
      fpc_q       <= fpc_d;
      wd_q        <= wd_d;
    end
  end

  always_comb begin
    busy_out         = (state_q == S_RUN);
    done_out         = (state_q == S_DONE);
    pass_out         = (state_q == S_DONE) && (err_q == '0) && !timeout_q && !bad_start_q;
    timeout_out      = timeout_q;
    x0_violation_out = x0_q;
    err_count_out    = err_q;
    fail_index_out   = fidx_q;
    fail_pc_out      = fpc_q;
  end

endmodule

// File: tb/tb_commit_trace_checker.sv
// Bench for commit_trace_checker: halting and non-halting instances share stimulus and are
// checked against a trace-level reference model.
module tb_commit_trace_checker;
  localparam int XLEN = 32, DEPTH = 128, TIMEOUT = 1024, AW = 7;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_n, load_valid, load_we, start, cv, cwe;
  logic [AW-1:0]   load_addr;
  logic [XLEN-1:0] load_pc, load_data, cpc, cdata;
  logic [4:0]      load_rd, crd;
  logic [AW:0]     num_entries;

  logic            busy_h, done_h, pass_h, to_h, x0_h;
  logic [AW:0]     err_h;
  logic [AW-1:0]   fidx_h;
  logic [XLEN-1:0] fpc_h;
  logic            busy_c, done_c, pass_c, to_c, x0_c;
  logic [AW:0]     err_c;
  logic [AW-1:0]   fidx_c;
  logic [XLEN-1:0] fpc_c;

  commit_trace_checker #(.XLEN(XLEN), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .HALT_ON_FAIL(1)) dut_h (
    .clk_100mhz(clk), .rst_in(rst_n), .load_valid_in(load_valid), .load_addr_in(load_addr),
    .load_pc_in(load_pc), .load_rd_in(load_rd), .load_we_in(load_we), .load_data_in(load_data),
    .num_entries_in(num_entries), .start_in(start), .commit_valid_in(cv), .commit_pc_in(cpc),
    .commit_rd_in(crd), .commit_we_in(cwe), .commit_data_in(cdata), .busy_out(busy_h),
    .done_out(done_h), .pass_out(pass_h), .timeout_out(to_h), .x0_violation_out(x0_h),
    .err_count_out(err_h), .fail_index_out(fidx_h), .fail_pc_out(fpc_h));

  commit_trace_checker #(.XLEN(XLEN), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .HALT_ON_FAIL(0)) dut_c (
    .clk_100mhz(clk), .rst_in(rst_n), .load_valid_in(load_valid), .load_addr_in(load_addr),
    .load_pc_in(load_pc), .load_rd_in(load_rd), .load_we_in(load_we), .load_data_in(load_data),
    .num_entries_in(num_entries), .start_in(start), .commit_valid_in(cv), .commit_pc_in(cpc),
    .commit_rd_in(crd), .commit_we_in(cwe), .commit_data_in(cdata), .busy_out(busy_c),
    .done_out(done_c), .pass_out(pass_c), .timeout_out(to_c), .x0_violation_out(x0_c),
    .err_count_out(err_c), .fail_index_out(fidx_c), .fail_pc_out(fpc_c));

  // Expected trace (what was loaded) and the commit stream to be replayed.
  logic [XLEN-1:0] t_pc [DEPTH], t_data [DEPTH], c_pc [DEPTH], c_data [DEPTH];
  logic [4:0]      t_rd [DEPTH], c_rd [DEPTH];
  logic            t_we [DEPTH], c_we [DEPTH];

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_addi(input int n);
    for (int i = 0; i < n; i++) begin
      t_pc[i] = 32'(4 * i); t_rd[i] = 5'd11; t_we[i] = 1'b1; t_data[i] = 32'(i + 1);
      c_pc[i] = t_pc[i]; c_rd[i] = t_rd[i]; c_we[i] = t_we[i]; c_data[i] = t_data[i];
    end
  endtask

  task automatic load_all(input int n, input bit start_on_last);
    for (int i = 0; i < n; i++) begin
      load_valid = 1'b1; load_addr = AW'(i);
      load_pc = t_pc[i]; load_rd = t_rd[i]; load_we = t_we[i]; load_data = t_data[i];
      num_entries = (AW+1)'(n);
      start = start_on_last && (i == n - 1);
      tick();
    end
    load_valid = 1'b0; start = 1'b0;
  endtask

  task automatic do_start(input int n);
    num_entries = (AW+1)'(n); start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic drive_commit(input int k);
    cv = 1'b1; cpc = c_pc[k]; crd = c_rd[k]; cwe = c_we[k]; cdata = c_data[k];
    tick();
    cv = 1'b0;
  endtask

  // Reference: walk the commit list entry by entry applying the comparison rules.
  task automatic model(input int n, input bit halt, output int stop_k, output int err,
                       output int fidx, output logic [31:0] fpc, output bit x0);
    err = 0; fidx = 0; fpc = '0; x0 = 1'b0; stop_k = n - 1;
    for (int k = 0; k < n; k++) begin
      bit bad, xh;
      xh  = c_we[k] && (c_rd[k] == 5'd0);
      bad = (c_pc[k] != t_pc[k]) || (c_we[k] != t_we[k]) ||
            (t_we[k] && ((c_rd[k] != t_rd[k]) || (c_data[k] != t_data[k]))) || xh;
      if (xh) x0 = 1'b1;
      if (bad) begin
        if (err == 0) begin fidx = k; fpc = c_pc[k]; end
        err++;
        if (halt) begin stop_k = k; break; end
      end
    end
  endtask

  // Feeds commits 0..n-1 after a run was started; disturb>=0 injects a load+start cycle
  // (both must be ignored in RUN) before that commit.
  task automatic run_check(input string tag, input int n, input int gapmax, input int disturb);
    int sh, eh, fih, sc, ec, fic;
    logic [31:0] fph, fpcc;
    bit xh, xc;
    model(n, 1'b1, sh, eh, fih, fph, xh);
    model(n, 1'b0, sc, ec, fic, fpcc, xc);
    for (int k = 0; k < n; k++) begin
      if (k == disturb) begin
        load_valid = 1'b1; load_addr = AW'(n - 1); load_pc = ~t_pc[n-1];
        load_rd = ~t_rd[n-1]; load_we = ~t_we[n-1]; load_data = ~t_data[n-1];
        start = 1'b1; num_entries = (AW+1)'(1);
        tick();
        load_valid = 1'b0; start = 1'b0;
      end
      repeat ($urandom_range(gapmax, 0)) tick();
      drive_commit(k);
      chk({tag, "/done_h_step"}, done_h, k >= sh);
      chk({tag, "/done_c_step"}, done_c, k >= sc);
    end
    tick();
    chk({tag, "/done_h"}, done_h, 1);   chk({tag, "/busy_h"}, busy_h, 0);
    chk({tag, "/pass_h"}, pass_h, eh == 0);
    chk({tag, "/err_h"}, err_h, eh);    chk({tag, "/fidx_h"}, fidx_h, fih);
    chk({tag, "/fpc_h"}, fpc_h, fph);   chk({tag, "/x0_h"}, x0_h, xh);
    chk({tag, "/to_h"}, to_h, 0);
    chk({tag, "/done_c"}, done_c, 1);   chk({tag, "/busy_c"}, busy_c, 0);
    chk({tag, "/pass_c"}, pass_c, ec == 0);
    chk({tag, "/err_c"}, err_c, ec);    chk({tag, "/fidx_c"}, fidx_c, fic);
    chk({tag, "/fpc_c"}, fpc_c, fpcc);  chk({tag, "/x0_c"}, x0_c, xc);
    chk({tag, "/to_c"}, to_c, 0);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "/busy"}, {busy_h, busy_c}, 0);  chk({tag, "/done"}, {done_h, done_c}, 0);
    chk({tag, "/pass"}, {pass_h, pass_c}, 0);  chk({tag, "/to"}, {to_h, to_c}, 0);
    chk({tag, "/x0"}, {x0_h, x0_c}, 0);        chk({tag, "/err"}, {err_h, err_c}, 0);
    chk({tag, "/fidx"}, {fidx_h, fidx_c}, 0);  chk({tag, "/fpc"}, {fpc_h, fpc_c}, 0);
  endtask

  initial begin
    int cyc;
    rst_n = 1'b0; load_valid = 1'b0; load_addr = '0; load_pc = '0; load_rd = '0;
    load_we = 1'b0; load_data = '0; num_entries = '0; start = 1'b0;
    cv = 1'b0; cpc = '0; crd = '0; cwe = 1'b0; cdata = '0;
    repeat (3) tick();
    chk_idle("reset");
    rst_n = 1'b1;

    // Full matching addi trace.
    set_addi(DEPTH);
    load_all(DEPTH, 1'b0);
    chk("idle_after_load", {busy_h, done_h}, 0);
    do_start(DEPTH);
    chk("busy_after_start", busy_h, 1);
    run_check("full_pass", DEPTH, 0, -1);

    // Commit 37 carries data 0.
    c_data[37] = '0;
    do_start(DEPTH);
    run_check("bad37", DEPTH, 0, -1);
    chk("bad37/fidx_const", fidx_h, 37);
    chk("bad37/fpc_const", fpc_h, 32'h94);
    c_data[37] = t_data[37];

    // Two corrupted entries.
    c_data[5] = 32'hdead; c_data[90] = 32'hbeef;
    do_start(DEPTH);
    run_check("bad5_90", DEPTH, 1, -1);
    chk("bad5_90/err_const", err_c, 2);
    c_data[5] = t_data[5]; c_data[90] = t_data[90];

    // addi x0,x0,1 present in both trace and commit stream.
    set_addi(16);
    t_rd[3] = 5'd0; c_rd[3] = 5'd0; t_data[3] = 32'd1; c_data[3] = 32'd1;
    load_all(16, 1'b0);
    do_start(16);
    run_check("x0", 16, 0, -1);
    chk("x0/flag_const", x0_c, 1);

    // Load and start ignored while running.
    set_addi(8);
    load_all(8, 1'b0);
    do_start(8);
    run_check("gating", 8, 0, 4);

    // Watchdog expiry with no commits.
    do_start(4);
    cyc = 0;
    while (!done_h && cyc < 2 * TIMEOUT) begin tick(); cyc++; end
    chk("timeout/latency", cyc, TIMEOUT);
    chk("timeout/flags", {done_h, to_h, pass_h, done_c, to_c, pass_c}, 6'b110110);

    // A commit in the watchdog's last cycle wins.
    do_start(2);
    repeat (TIMEOUT - 1) tick();
    drive_commit(0);
    chk("wd_edge/busy", busy_h, 1);
    chk("wd_edge/to", to_h, 0);
    repeat (TIMEOUT - 1) tick();
    drive_commit(1);
    chk("wd_edge/pass", {done_h, pass_h, to_h}, 3'b110);

    // Reset at commit 50, then restart without reload.
    set_addi(DEPTH);
    load_all(DEPTH, 1'b0);
    do_start(DEPTH);
    for (int k = 0; k < 50; k++) drive_commit(k);
    chk("midreset/busy_before", busy_h, 1);
    rst_n = 1'b0;
    tick();
    chk_idle("midreset");
    rst_n = 1'b1;
    do_start(DEPTH);
    run_check("restart", DEPTH, 0, -1);

    // Illegal lengths.
    do_start(0);
    chk("n0/flags", {done_h, busy_h, pass_h, done_c, pass_c}, 5'b10010);
    chk("n0/err", err_h, 0);
    do_start(DEPTH + 1);
    chk("n129/flags", {done_h, busy_h, pass_h, done_c, pass_c}, 5'b10010);

    // Randomized traces with sparse corruption and gaps.
    for (int it = 0; it < 6; it++) begin
      int n, sh, eh, fih;
      logic [31:0] fph;
      bit xh;
      n = $urandom_range(DEPTH, 1);
      for (int i = 0; i < n; i++) begin
        t_pc[i] = $urandom; t_we[i] = 1'($urandom_range(1, 0)); t_data[i] = $urandom;
        t_rd[i] = ($urandom_range(15, 0) == 0) ? 5'd0 : 5'($urandom_range(31, 1));
        c_pc[i] = t_pc[i]; c_rd[i] = t_rd[i]; c_we[i] = t_we[i]; c_data[i] = t_data[i];
        if ($urandom_range(11, 0) == 0) begin
          case ($urandom_range(3, 0))
            0: c_pc[i] = c_pc[i] ^ (32'd1 << $urandom_range(31, 0));
            1: c_we[i] = ~c_we[i];
            2: c_rd[i] = c_rd[i] ^ 5'($urandom_range(31, 1));
            default: c_data[i] = c_data[i] ^ (32'd1 << $urandom_range(31, 0));
          endcase
        end
      end
      load_all(n, it[0]);
      if (!it[0]) do_start(n);
      model(n, 1'b1, sh, eh, fih, fph, xh);
      run_check($sformatf("rand%0d", it), n, 3, $urandom_range(sh, 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
